// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard controller's pipeline-facing signals.
//   master modport: the core side. It drives the hazard inputs and
//     receives the enables, flushes and forwarding selects.
//   slave modport: the hazard controller itself.
//   Inputs to controller:
//     id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used,
//     ex_rd_addr, ex_reg_wb, ex_mem_read,
//     mem_rd_addr, mem_reg_wb, branch_taken, mem_busy.
//   Outputs from controller:
//     pc_en, fd_en, fd_flush, ex_en, ex_flush, mem_en,
//     fwd_a_sel, fwd_b_sel.
//   Optional, only with HAZ_PERF_CNT_EN defined: stall_cycles, flush_events.
interface pipeline_hazard_ctrl_if;
  logic [2:0]  id_rs1_addr;
  logic [2:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [2:0]  ex_rd_addr;
  logic        ex_reg_wb;
  logic        ex_mem_read;
  logic [2:0]  mem_rd_addr;
  logic        mem_reg_wb;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_en;
  logic        fd_en;
  logic        fd_flush;
  logic        ex_en;
  logic        ex_flush;
  logic        mem_en;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_reg_wb, ex_mem_read, mem_rd_addr, mem_reg_wb,
           branch_taken, mem_busy,
    input  pc_en, fd_en, fd_flush, ex_en, ex_flush, mem_en,
           fwd_a_sel, fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
    , input stall_cycles, flush_events
`endif
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_reg_wb, ex_mem_read, mem_rd_addr, mem_reg_wb,
           branch_taken, mem_busy,
    output pc_en, fd_en, fd_flush, ex_en, ex_flush, mem_en,
           fwd_a_sel, fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
    , output stall_cycles, flush_events
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall / flush / forwarding controller for the 10-bit core.
//   Sequences load-use bubbles, taken-branch flush penalties and
//   memory-wait freezes with a small state machine (st, cnt). All
//   outputs are combinational from st, cnt and the current inputs.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     hz    : pipeline_hazard_ctrl_if.slave (hazard inputs, enables,
//             flushes, forwarding selects)
//   Optional feature macro HAZ_PERF_CNT_EN: adds saturating 16-bit
//   stall_cycles / flush_events counters on the interface.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY    = 1,
  parameter int R0_IS_ZERO        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } st_t;

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] BR_RELOAD = 3'(BRANCH_PENALTY - 1);

  st_t        st;
  logic [2:0] cnt;
  logic       load_use;

  // Register 0 is hardwired to zero, so it never produces a real dependency.
  function automatic logic addr_match(input logic [2:0] x, input logic [2:0] y);
    return (x == y) && !((R0_IS_ZERO != 0) && (x == 3'd0));
  endfunction

  // A load still in EX-MEM cannot forward; it falls through to MEM-WB or regfile.
  function automatic logic [1:0] fwd_sel(input logic [2:0] rs);
    if (hz.ex_reg_wb && !hz.ex_mem_read && addr_match(hz.ex_rd_addr, rs))
      return 2'b01;
    else if (hz.mem_reg_wb && addr_match(hz.mem_rd_addr, rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign load_use = hz.ex_mem_read && hz.ex_reg_wb &&
                    ((hz.id_rs1_used && addr_match(hz.ex_rd_addr, hz.id_rs1_addr)) ||
                     (hz.id_rs2_used && addr_match(hz.ex_rd_addr, hz.id_rs2_addr)));

  // Output decode: reset > mem_busy > branch_taken > stall/flush sequencing
  always_comb begin
    hz.pc_en     = 1'b1;
    hz.fd_en     = 1'b1;
    hz.fd_flush  = 1'b0;
    hz.ex_en     = 1'b1;
    hz.ex_flush  = 1'b0;
    hz.mem_en    = 1'b1;
    hz.fwd_a_sel = fwd_sel(hz.id_rs1_addr);
    hz.fwd_b_sel = fwd_sel(hz.id_rs2_addr);
    if (reset) begin
      hz.pc_en     = 1'b0;
      hz.fd_en     = 1'b0;
      hz.ex_en     = 1'b0;
      hz.mem_en    = 1'b0;
      hz.fd_flush  = 1'b1;
      hz.ex_flush  = 1'b1;
      hz.fwd_a_sel = 2'b00;
      hz.fwd_b_sel = 2'b00;
    end else if (hz.mem_busy) begin
      hz.pc_en  = 1'b0;
      hz.fd_en  = 1'b0;
      hz.ex_en  = 1'b0;
      hz.mem_en = 1'b0;
    end else if (hz.branch_taken) begin
      hz.fd_flush = 1'b1;
      hz.ex_flush = 1'b1;
    end else if (st == BR_FLUSH) begin
      hz.fd_flush = 1'b1;
    end else if (st == LD_STALL || load_use) begin
      hz.pc_en    = 1'b0;
      hz.fd_en    = 1'b0;
      hz.ex_flush = 1'b1;
    end
  end

  // State register: a freeze holds st/cnt; cnt exits at 1 so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= RUN;
      cnt <= 3'd0;
    end else if (!hz.mem_busy) begin
      if (hz.branch_taken) begin
        if (BRANCH_PENALTY > 1) begin
          st  <= BR_FLUSH;
          cnt <= BR_RELOAD;
        end else begin
          st  <= RUN;
          cnt <= 3'd0;
        end
      end else begin
        case (st)
          RUN: begin
            if (load_use && (LOAD_STALL_CYCLES > 1)) begin
              st  <= LD_STALL;
              cnt <= LD_RELOAD;
            end
          end
          LD_STALL, BR_FLUSH: begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1)
              st <= RUN;
          end
          default: begin
            st  <= RUN;
            cnt <= 3'd0;
          end
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      hz.stall_cycles <= 16'd0;
      hz.flush_events <= 16'd0;
    end else begin
      if (!hz.pc_en && (hz.stall_cycles != 16'hFFFF))
        hz.stall_cycles <= hz.stall_cycles + 16'd1;
      if (hz.branch_taken && !hz.mem_busy && (hz.flush_events != 16'hFFFF))
        hz.flush_events <= hz.flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed scenarios followed by randomized traffic for
//   pipeline_hazard_ctrl (LOAD_STALL_CYCLES=2, BRANCH_PENALTY=3,
//   R0_IS_ZERO=1). Expected outputs come from a reference model that
//   tracks remaining stall / flush cycles as plain integers.
module tb_pipeline_hazard_ctrl;
  localparam int LSC = 2;
  localparam int BP  = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES (LSC),
    .BRANCH_PENALTY    (BP),
    .R0_IS_ZERO        (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // Reference model state
  int stall_rem = 0;
  int flush_rem = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  logic e_pc_en, e_fd_en, e_fd_flush, e_ex_en, e_ex_flush, e_mem_en;
  logic [1:0] e_fwd_a, e_fwd_b;
  logic s_pc_en, s_fd_en, s_fd_flush, s_ex_en, s_ex_flush, s_mem_en;
  logic [1:0] s_fwd_a, s_fwd_b;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_match(input logic [2:0] x, input logic [2:0] y);
    return (x == y) && (x != 3'd0);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [2:0] rs);
    if (hz.ex_reg_wb && !hz.ex_mem_read && m_match(hz.ex_rd_addr, rs)) return 2'b01;
    if (hz.mem_reg_wb && m_match(hz.mem_rd_addr, rs)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_enables(input logic pc, fd, fdf, ex, exf, mem);
    e_pc_en = pc; e_fd_en = fd; e_fd_flush = fdf;
    e_ex_en = ex; e_ex_flush = exf; e_mem_en = mem;
  endtask

  task automatic model_eval();
    bit lu;
    lu = hz.ex_mem_read && hz.ex_reg_wb &&
         ((hz.id_rs1_used && m_match(hz.ex_rd_addr, hz.id_rs1_addr)) ||
          (hz.id_rs2_used && m_match(hz.ex_rd_addr, hz.id_rs2_addr)));
    e_fwd_a = m_fwd(hz.id_rs1_addr);
    e_fwd_b = m_fwd(hz.id_rs2_addr);
    if (reset) begin
      set_enables(0, 0, 1, 0, 1, 0);
      e_fwd_a = 2'b00; e_fwd_b = 2'b00;
    end else if (hz.mem_busy) set_enables(0, 0, 0, 0, 0, 0);
    else if (hz.branch_taken) set_enables(1, 1, 1, 1, 1, 1);
    else if (flush_rem > 0)   set_enables(1, 1, 1, 1, 0, 1);
    else if (stall_rem > 0 || lu) set_enables(0, 0, 0, 1, 1, 1);
    else set_enables(1, 1, 0, 1, 0, 1);
    // Pending remaining cycles after this one, applied at commit
    if (reset) begin
      stall_rem = 0; flush_rem = 0;
    end else if (!hz.mem_busy) begin
      if (hz.branch_taken) begin
        flush_rem = BP - 1; stall_rem = 0;
      end else if (flush_rem > 0) flush_rem--;
      else if (stall_rem > 0) stall_rem--;
      else if (lu) stall_rem = LSC - 1;
    end
    if (reset) begin
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!e_pc_en && m_stall_cnt < 65535) m_stall_cnt++;
      if (hz.branch_taken && !hz.mem_busy && m_flush_cnt < 65535) m_flush_cnt++;
    end
  endtask

  // One clock: sample and compare at negedge, then advance past posedge.
  task automatic do_cycle(input string tag);
`ifdef HAZ_PERF_CNT_EN
    int pre_stall, pre_flush;
`endif
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    pre_stall = m_stall_cnt; pre_flush = m_flush_cnt;
    chk({tag, ".stall_cycles"}, hz.stall_cycles, 16'(pre_stall));
    chk({tag, ".flush_events"}, hz.flush_events, 16'(pre_flush));
`endif
    model_eval();
    s_pc_en = hz.pc_en; s_fd_en = hz.fd_en; s_fd_flush = hz.fd_flush;
    s_ex_en = hz.ex_en; s_ex_flush = hz.ex_flush; s_mem_en = hz.mem_en;
    s_fwd_a = hz.fwd_a_sel; s_fwd_b = hz.fwd_b_sel;
    chk({tag, ".pc_en"},    16'(s_pc_en),    16'(e_pc_en));
    chk({tag, ".fd_en"},    16'(s_fd_en),    16'(e_fd_en));
    chk({tag, ".fd_flush"}, 16'(s_fd_flush), 16'(e_fd_flush));
    chk({tag, ".ex_en"},    16'(s_ex_en),    16'(e_ex_en));
    chk({tag, ".ex_flush"}, 16'(s_ex_flush), 16'(e_ex_flush));
    chk({tag, ".mem_en"},   16'(s_mem_en),   16'(e_mem_en));
    chk({tag, ".fwd_a"},    16'(s_fwd_a),    16'(e_fwd_a));
    chk({tag, ".fwd_b"},    16'(s_fwd_b),    16'(e_fwd_b));
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hz.id_rs1_addr = 3'd1; hz.id_rs2_addr = 3'd2;
    hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
    hz.ex_rd_addr = 3'd6;  hz.ex_reg_wb = 1'b0; hz.ex_mem_read = 1'b0;
    hz.mem_rd_addr = 3'd7; hz.mem_reg_wb = 1'b0;
    hz.branch_taken = 1'b0; hz.mem_busy = 1'b0;
  endtask

  task automatic set_load_use(input logic [2:0] a);
    hz.ex_mem_read = 1'b1; hz.ex_reg_wb = 1'b1; hz.ex_rd_addr = a;
    hz.id_rs1_addr = a; hz.id_rs1_used = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    // Reset state
    do_cycle("reset");
    chk("reset.pc_en_const", 16'(s_pc_en), 16'd0);
    chk("reset.fd_flush_const", 16'(s_fd_flush), 16'd1);
    reset = 1'b0;
    do_cycle("idle");
    chk("idle.pc_en_const", 16'(s_pc_en), 16'd1);

    // Load-use, two bubble cycles
    set_load_use(3'd3);
    do_cycle("lu0");
    chk("lu0.pc_en_const", 16'(s_pc_en), 16'd0);
    chk("lu0.ex_flush_const", 16'(s_ex_flush), 16'd1);
    set_idle();
    do_cycle("lu1");
    chk("lu1.fd_en_const", 16'(s_fd_en), 16'd0);
    do_cycle("lu2");
    chk("lu2.pc_en_const", 16'(s_pc_en), 16'd1);

    // R0 never hazards
    set_load_use(3'd0);
    hz.ex_mem_read = 1'b0;
    do_cycle("r0fwd");
    chk("r0fwd.fwd_a_const", 16'(s_fwd_a), 16'd0);
    hz.ex_mem_read = 1'b1;
    do_cycle("r0lu");
    chk("r0lu.pc_en_const", 16'(s_pc_en), 16'd1);
    set_idle();

    // Branch penalty of three cycles
    hz.branch_taken = 1'b1;
    do_cycle("br0");
    chk("br0.ex_flush_const", 16'(s_ex_flush), 16'd1);
    chk("br0.fd_flush_const", 16'(s_fd_flush), 16'd1);
    hz.branch_taken = 1'b0;
    do_cycle("br1");
    chk("br1.fd_flush_const", 16'(s_fd_flush), 16'd1);
    chk("br1.ex_flush_const", 16'(s_ex_flush), 16'd0);
    do_cycle("br2");
    chk("br2.fd_flush_const", 16'(s_fd_flush), 16'd1);
    chk("br2.pc_en_const", 16'(s_pc_en), 16'd1);
    do_cycle("br3");
    chk("br3.fd_flush_const", 16'(s_fd_flush), 16'd0);

    // Freeze in the middle of a load stall
    set_load_use(3'd4);
    do_cycle("fz_lu");
    set_idle();
    hz.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_cycle("fz_busy");
      chk("fz_busy.mem_en_const", 16'(s_mem_en), 16'd0);
    end
    hz.mem_busy = 1'b0;
    do_cycle("fz_rel");
    chk("fz_rel.pc_en_const", 16'(s_pc_en), 16'd0);
    do_cycle("fz_done");
    chk("fz_done.pc_en_const", 16'(s_pc_en), 16'd1);

    // Forwarding priority
    hz.ex_rd_addr = 3'd5; hz.ex_reg_wb = 1'b1;
    hz.mem_rd_addr = 3'd5; hz.mem_reg_wb = 1'b1;
    hz.id_rs2_addr = 3'd5; hz.id_rs2_used = 1'b1;
    do_cycle("fwd_ex");
    chk("fwd_ex.fwd_b_const", 16'(s_fwd_b), 16'd1);
    hz.ex_mem_read = 1'b1;
    do_cycle("fwd_ld");
    chk("fwd_ld.fwd_b_const", 16'(s_fwd_b), 16'd2);
    chk("fwd_ld.pc_en_const", 16'(s_pc_en), 16'd0);
    set_idle();
    do_cycle("fwd_tail");

    // Reset in the middle of a branch flush
    hz.branch_taken = 1'b1;
    do_cycle("rbr0");
    hz.branch_taken = 1'b0;
    do_cycle("rbr1");
    reset = 1'b1;
    do_cycle("rbr_rst");
    chk("rbr_rst.ex_en_const", 16'(s_ex_en), 16'd0);
    reset = 1'b0;
    do_cycle("rbr_run");
    chk("rbr_run.fd_flush_const", 16'(s_fd_flush), 16'd0);
    chk("rbr_run.pc_en_const", 16'(s_pc_en), 16'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      hz.id_rs1_addr  = 3'($urandom_range(0, 3));
      hz.id_rs2_addr  = 3'($urandom_range(0, 3));
      hz.id_rs1_used  = 1'($urandom);
      hz.id_rs2_used  = 1'($urandom);
      hz.ex_rd_addr   = 3'($urandom_range(0, 3));
      hz.ex_reg_wb    = 1'($urandom);
      hz.ex_mem_read  = 1'($urandom);
      hz.mem_rd_addr  = 3'($urandom_range(0, 3));
      hz.mem_reg_wb   = 1'($urandom);
      hz.branch_taken = ($urandom_range(0, 7) == 0);
      hz.mem_busy     = ($urandom_range(0, 5) == 0);
      do_cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
